// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB register completer.
// Optional wait states: APB_COMPLETER_WAIT_EN.
package apb_completer_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int APB_DEV_W  = 4;

  // STATUS register field positions
  localparam int STAT_WR_HI  = 7;
  localparam int STAT_WR_LO  = 4;
  localparam int STAT_ERR_HI = 3;
  localparam int STAT_ERR_LO = 0;

`ifdef APB_COMPLETER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_completer_regfile.sv
// Register bank, STATUS counters, registered read mux, error detect.
// Used by apb_reg_completer.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int              NUM_REGS  = 8,
  parameter logic [7:0]      RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [APB_ADDR_W-1:0] addr,
  input  logic                  wr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic                  load,
  input  logic                  commit,
  output logic [APB_DATA_W-1:0] rdata,
  output logic                  slverr
);

  localparam int NW = NUM_REGS - 1;
  localparam logic [APB_ADDR_W-1:0] STAT_IDX =
    APB_ADDR_W'(NUM_REGS - 1);
  localparam logic [APB_ADDR_W-1:0] LIMIT =
    APB_ADDR_W'(NUM_REGS);

  logic [APB_DATA_W-1:0] regs [NW];
  logic [3:0]            wr_cnt;
  logic [3:0]            err_cnt;
  logic [APB_DATA_W-1:0] status;
  logic [APB_DATA_W-1:0] rd_mux;
  logic                  err;

  assign err = (addr >= LIMIT) || (wr && addr == STAT_IDX);

  // assemble STATUS from the two counters
  always_comb begin
    status = '0;
    status[STAT_WR_HI:STAT_WR_LO]   = wr_cnt;
    status[STAT_ERR_HI:STAT_ERR_LO] = err_cnt;
  end

  // read mux over the writable bank plus STATUS
  always_comb begin
    rd_mux = '0;
    if (addr == STAT_IDX)
      rd_mux = status;
    for (int i = 0; i < NW; i++)
      if (addr == APB_ADDR_W'(i))
        rd_mux = regs[i];
  end

  // response registered on entry to ACCESS, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      slverr <= 1'b0;
    end else if (load) begin
      slverr <= err;
      rdata  <= (err || wr) ? '0 : rd_mux;
    end else begin
      rdata  <= '0;
      slverr <= 1'b0;
    end
  end

  // writes land at the edge that ends ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++)
        regs[i] <= RESET_VAL;
    end else if (commit && wr && !err) begin
      for (int i = 0; i < NW; i++)
        if (addr == APB_ADDR_W'(i))
          regs[i] <= wdata;
    end
  end

  // good-write count wraps, error count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (commit) begin
      if (err) begin
        if (err_cnt != 4'hF)
          err_cnt <= err_cnt + 4'd1;
      end else if (wr) begin
        wr_cnt <= wr_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: device decode and transfer FSM.
// Wait states present only with APB_COMPLETER_WAIT_EN.
module apb_reg_completer
  import apb_completer_pkg::*;
#(
  parameter logic [3:0] DEVICE_ID   = 4'h1,
  parameter int         NUM_REGS    = 8,
  parameter int         WAIT_CYCLES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  apb_sel,
  input  logic                  apb_enable,
  input  logic [APB_DEV_W-1:0]  apb_device,
  input  logic [APB_ADDR_W-1:0] apb_addr,
  input  logic                  apb_write,
  input  logic [APB_DATA_W-1:0] apb_data,
  output logic [APB_DATA_W-1:0] apb_rdata,
  output logic                  ready,
  output logic                  apb_slverr
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;

  localparam logic [3:0] W_EFF =
    WAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;

  logic [1:0]            state;
  logic [1:0]            next;
  logic                  hit;
  logic                  go;
  logic                  start;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  wr_q;
  logic [APB_DATA_W-1:0] data_q;

  assign hit   = apb_sel && (apb_device == DEVICE_ID);
  assign go    = hit && apb_enable;
  assign start = (state == S_IDLE) && hit && !apb_enable;
  assign ready = (state == S_ACCESS);

`ifdef APB_COMPLETER_WAIT_EN
  logic [3:0] wait_cnt;

  // wait-state down-counter, loaded in SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (state == S_SETUP)
      wait_cnt <= W_EFF - 4'd1;
    else if (state == S_WAIT && wait_cnt != 4'd0)
      wait_cnt <= wait_cnt - 4'd1;
  end
`endif

  // next-state logic; a dropped sel/enable abandons the transfer
  always_comb begin
    next = state;
    case (state)
      S_IDLE:
        if (start) next = S_SETUP;
      S_SETUP:
        if (!go)
          next = S_IDLE;
        else if (W_EFF != 4'd0)
          next = S_WAIT;
        else
          next = S_ACCESS;
`ifdef APB_COMPLETER_WAIT_EN
      S_WAIT:
        if (!go)
          next = S_IDLE;
        else if (wait_cnt == 4'd0)
          next = S_ACCESS;
`endif
      S_ACCESS:
        next = S_IDLE;
      default:
        next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= next;
  end

  // capture the request during the bus setup phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else if (start) begin
      addr_q <= apb_addr;
      wr_q   <= apb_write;
      data_q <= apb_data;
    end
  end

  apb_completer_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr_q),
    .wr     (wr_q),
    .wdata  (data_q),
    .load   (next == S_ACCESS),
    .commit (state == S_ACCESS),
    .rdata  (apb_rdata),
    .slverr (apb_slverr)
  );

endmodule
